// File: rtl/itl_pkg.sv
// Shared types and constants for the lane serializer: PB size encodings,
// per-PB beat counts, lane geometry and the serializer state enum.
package itl_pkg;

    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 2;
    localparam int WORD_W    = NUM_LANES * VEC_W;
    localparam int LANE_IW   = $clog2(NUM_LANES);
    localparam int BEAT_CW   = 10;
    localparam int SYM_CW    = 12;

    typedef enum logic [1:0] {
        PB16    = 2'd0,
        PB136   = 2'd1,
        PB520   = 2'd2,
        PB_RSVD = 2'd3
    } pb_size_e;

    localparam logic [BEAT_CW-1:0] NB_PB16  = 10'd16;
    localparam logic [BEAT_CW-1:0] NB_PB136 = 10'd136;
    localparam logic [BEAT_CW-1:0] NB_PB520 = 10'd520;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_e;

    // Reserved encoding falls back to the shortest PB.
    function automatic logic [BEAT_CW-1:0] pb_beats(input logic [1:0] sz);
        case (pb_size_e'(sz))
            PB136:   return NB_PB136;
            PB520:   return NB_PB520;
            default: return NB_PB16;
        endcase
    endfunction

endpackage

// File: rtl/ser_word_fifo.sv
// DEPTH x WORD_W word FIFO with synchronous flush and occupancy count.
// A push into a full FIFO is taken when a pop frees the slot in the same cycle.
module ser_word_fifo
    import itl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic [WORD_W-1:0] rdata,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic              full, do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/itl_lane_serializer.sv
// Buffers 4-lane interleaver beats and serializes them into a 2-bit symbol
// stream with valid/ready, PB-length tracking and overflow flag. Optional macro SER_OCC_EN adds occ.
module itl_lane_serializer
    import itl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] pb_size,
    input  logic       frame_start,
    input  logic       in_vld,
    input  logic [1:0] in_lane0,
    input  logic [1:0] in_lane1,
    input  logic [1:0] in_lane2,
    input  logic [1:0] in_lane3,
    output logic [1:0] dout,
    output logic       dout_vld,
    input  logic       dout_rdy,
    output logic       dout_last,
    output logic       ovf,
    output logic       busy
`ifdef SER_OCC_EN
    ,
    output logic [AW:0] occ
`endif
);

    ser_state_e         state, state_nxt;
    logic [BEAT_CW-1:0] nb, beat_cnt;
    logic [SYM_CW-1:0]  sym_cnt, last_sym;
    logic [WORD_W-1:0]  sh, rd_word, wr_word;
    logic [LANE_IW-1:0] idx;
    logic [AW:0]        fifo_cnt;
    logic               fifo_empty;
    logic               run, acc, pop, push, room, drop;

    assign wr_word  = {in_lane3, in_lane2, in_lane1, in_lane0};
    assign run      = (state == RUN) && !frame_start;
    assign acc      = dout_vld && dout_rdy;
    assign last_sym = {nb, 2'b00} - SYM_CW'(1);
    assign dout_last = dout_vld && (sym_cnt == last_sym);
    assign dout     = sh[VEC_W-1:0];
    assign busy     = (state != IDLE);

    // Reload the holding word when idle or as its final lane is taken, so a
    // steady FIFO feeds the output with no bubble.
    assign pop  = run && !fifo_empty &&
                  (!dout_vld || (acc && idx == LANE_IW'(NUM_LANES-1) && !dout_last));
    assign room = (fifo_cnt != (AW+1)'(DEPTH)) || pop;
    assign push = run && in_vld && (beat_cnt != nb) && room;
    assign drop = !frame_start && in_vld &&
                  (((state == RUN) && !push) || (state == DONE));

    ser_word_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .flush (frame_start),
        .push  (push),
        .wdata (wr_word),
        .pop   (pop),
        .rdata (rd_word),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

`ifdef SER_OCC_EN
    assign occ = fifo_cnt;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_start)
            state_nxt = RUN;
        else if ((state == RUN) && acc && dout_last)
            state_nxt = DONE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            nb       <= NB_PB16;
            beat_cnt <= '0;
            sym_cnt  <= '0;
            ovf      <= 1'b0;
            sh       <= '0;
            idx      <= '0;
            dout_vld <= 1'b0;
        end else if (frame_start) begin
            nb       <= pb_beats(pb_size);
            beat_cnt <= '0;
            sym_cnt  <= '0;
            ovf      <= 1'b0;
            idx      <= '0;
            dout_vld <= 1'b0;
        end else begin
            if (push) beat_cnt <= beat_cnt + 1'b1;
            if (drop) ovf <= 1'b1;
            if (acc)  sym_cnt <= sym_cnt + 1'b1;
            if (pop) begin
                sh       <= rd_word;
                idx      <= '0;
                dout_vld <= 1'b1;
            end else if (acc) begin
                if (idx == LANE_IW'(NUM_LANES-1) || dout_last) begin
                    dout_vld <= 1'b0;
                end else begin
                    sh  <= sh >> VEC_W;
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule
